// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: fetches the word at pc, holds it until the core consumes it.
// Optional WAIT-state timeout fault is compiled in when IFU_TIMEOUT_EN is defined.
module ysyx_23060278_ifu #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic              pc_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [DATA_W-1:0] mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              fetch_err,
  output logic [1:0]        err_cause,
  output logic [2:0]        state_dbg
);

  if (DATA_W != 32 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_cfg
    $error("ysyx_23060278_ifu: DATA_W must be 32 and TIMEOUT_CYC within 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] inst_nxt;
  logic [1:0]        cause_nxt;

`ifdef IFU_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt, wait_cnt_nxt;
`endif

  // All handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; a raised valid (and its payload) stays stable until that edge.
  assign mem_req_addr  = pc;
  assign mem_req_valid = (state == S_REQ) && (pc[1:0] == 2'b00);
  assign mem_rsp_ready = (state == S_WAIT);
  assign inst_valid    = (state == S_HOLD);
  assign fetch_err     = (state == S_ERR);
  assign pc_wen        = inst_valid & inst_ready;
  assign state_dbg     = state;

  always_comb begin
    state_nxt = state;
    inst_nxt  = inst;
    cause_nxt = err_cause;
`ifdef IFU_TIMEOUT_EN
    wait_cnt_nxt = wait_cnt;
`endif
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (pc[1:0] != 2'b00) begin
          state_nxt = S_ERR;
          cause_nxt = 2'b01;
        end else if (mem_req_ready) begin
          state_nxt = S_WAIT;
`ifdef IFU_TIMEOUT_EN
          wait_cnt_nxt = 8'd0;
`endif
        end
      end
      S_WAIT: begin
        // A response, good or bad, always beats a timeout in the same cycle.
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            state_nxt = S_ERR;
            cause_nxt = 2'b10;
          end else begin
            state_nxt = S_HOLD;
            inst_nxt  = mem_rsp_data;
          end
        end
`ifdef IFU_TIMEOUT_EN
        else if (wait_cnt == TIMEOUT_LAST) begin
          state_nxt = S_ERR;
          cause_nxt = 2'b11;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
`endif
      end
      S_HOLD: if (inst_ready) state_nxt = S_REQ;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      inst      <= '0;
      err_cause <= 2'b00;
`ifdef IFU_TIMEOUT_EN
      wait_cnt  <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      inst      <= inst_nxt;
      err_cause <= cause_nxt;
`ifdef IFU_TIMEOUT_EN
      wait_cnt  <= wait_cnt_nxt;
`endif
    end
  end

endmodule
